// File: rtl/int_dp_pkg.sv
// Shared encodings for the integer datapath: mul/div opcodes, iterative unit FSM
// states and HI/LO direct-load bit positions.
package int_dp_pkg;

  typedef enum logic [1:0] {
    OpMultu = 2'b00,
    OpMult  = 2'b01,
    OpDivu  = 2'b10,
    OpDiv   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StIter = 2'b01,
    StFix  = 2'b10
  } state_e;

  // Opcode bit meanings: bit1 selects divide, bit0 selects signed.
  localparam int unsigned OpDivBit    = 1;
  localparam int unsigned OpSignedBit = 0;

  localparam int unsigned HiloWrHi = 1;
  localparam int unsigned HiloWrLo = 0;

endpackage

// File: rtl/muldiv_iter_core.sv
// One iteration of the shared 2*WIDTH accumulator: radix-2 shift-add multiply step or
// restoring divide step. Purely combinational, no control or HI/LO state.
module muldiv_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             fits;

  always_comb begin
    // Multiply: upper half accumulates, multiplier drains out of the low end.
    mul_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} +
               {1'b0, (acc_i[0] ? opnd_i : {WIDTH{1'b0}})};
    // Divide: partial remainder shifted left needs one extra bit before the compare.
    rem_sh   = acc_i[2*WIDTH-1:WIDTH-1];
    rem_diff = rem_sh[WIDTH-1:0] - opnd_i;
    fits     = rem_sh >= {1'b0, opnd_i};
    if (is_div_i) begin
      acc_o = fits ? {rem_diff, acc_i[WIDTH-2:0], 1'b1}
                   : {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/iter_muldiv_hilo.sv
// Multi-cycle signed/unsigned multiply/divide unit with architectural HI/LO registers,
// driven by a start/busy/done handshake.
module iter_muldiv_hilo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] t_in,
  input  logic [1:0]       hilo_wr,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  import int_dp_pkg::*;

  localparam int unsigned      CNT_W   = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_step, prod;
  logic [WIDTH-1:0]   opnd_q, hi_q, lo_q;
  logic [WIDTH-1:0]   s_mag, t_mag, quot, rem, res_hi, res_lo;
  logic               is_div_q, neg_q, neg_s_q, dz_pend_q, dz_q, done_q;
  logic               s_neg, t_neg, div_by_zero;
  logic               idle, iter_en, fix_en, accept;

  always_comb begin
    s_neg       = op[OpSignedBit] & s_in[WIDTH-1];
    t_neg       = op[OpSignedBit] & t_in[WIDTH-1];
    s_mag       = s_neg ? -s_in : s_in;
    t_mag       = t_neg ? -t_in : t_in;
    div_by_zero = op[OpDivBit] && (t_in == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = div_by_zero ? StFix : StIter;
      StIter:  if (cnt_q == LastCnt) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idle    = (state_q == StIdle);
    iter_en = (state_q == StIter);
    fix_en  = (state_q == StFix);
    busy    = !idle;
    accept  = idle && start;
  end

  muldiv_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_step)
  );

  // Sign fix-up: iteration works on magnitudes only.
  always_comb begin
    prod   = neg_q ? -acc_q : acc_q;
    quot   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem    = neg_s_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    res_hi = is_div_q ? rem  : prod[2*WIDTH-1:WIDTH];
    res_lo = is_div_q ? quot : prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_s_q   <= 1'b0;
      dz_pend_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= fix_en;
      if (accept) begin
        cnt_q     <= '0;
        acc_q     <= {{WIDTH{1'b0}}, s_mag};
        opnd_q    <= t_mag;
        is_div_q  <= op[OpDivBit];
        neg_q     <= s_neg ^ t_neg;
        neg_s_q   <= s_neg;
        dz_pend_q <= div_by_zero;
      end else if (iter_en) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (fix_en) begin
        dz_q <= dz_pend_q;
        if (!dz_pend_q) begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
      end else if (idle) begin
        if (hilo_wr[HiloWrHi]) hi_q <= s_in;
        if (hilo_wr[HiloWrLo]) lo_q <= s_in;
      end
    end
  end

  assign done   = done_q;
  assign dz     = dz_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: doc/iter_muldiv_hilo.md
Name: iter_muldiv_hilo

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It replaces the single-cycle combinational MUL/DIV path and HI/LO load of the integer datapath. It supports signed and unsigned operation at any WIDTH through a start/busy/done handshake. The datapath's control stalls on busy, then reads HI/LO through its Y-select mux as before.

Parameters:
WIDTH, 32, operand and HI/LO width; must be >= 4.
CNT_W, $clog2(WIDTH+1), iteration counter width; localparam, not overridable.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request; sampled on rising edge only while idle
op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
s_in  in  WIDTH  S operand: multiplicand or dividend
t_in  in  WIDTH  T operand: multiplier or divisor
hilo_wr  in  2  direct load: bit1 HI<=s_in, bit0 LO<=s_in (MTHI/MTLO); honoured only while idle
busy  out  1  operation in flight
done  out  1  one-cycle pulse; HI/LO valid this cycle
dz  out  1  sticky divide-by-zero flag of last completed op
hi_out  out  WIDTH  HI register
lo_out  out  WIDTH  LO register

Behaviour:
- Reset (asynchronous, immediate): busy=0, done=0, dz=0, hi_out=0, lo_out=0, FSM=IDLE, counter=0. Reset mid-operation aborts the operation with no HI/LO write.
- FSM states:
  - IDLE -> ITER on an edge with start=1 (edge E0).
  - ITER runs for exactly WIDTH edges (E1..E_WIDTH), then goes to FIX.
  - FIX writes HI/LO and returns to IDLE on E_{WIDTH+1}.
- busy is high from after E0 until after E_{WIDTH+1}. done is high for the single cycle after E_{WIDTH+1}. Latency from start to done is WIDTH+1 cycles.
- Operands and op are captured at E0. Later changes on s_in, t_in or op have no effect.
- Signed ops (MULT, DIV):
  - Iterate on magnitudes; record sign of S, sign of T and their XOR at E0.
  - FIX negates the product when the signs differ.
  - FIX negates the quotient when the signs differ.
  - The remainder takes the sign of the dividend.
- Multiply: radix-2 shift-add over a 2*WIDTH accumulator. HI = upper half, LO = lower half of the full product.
- Divide: restoring, one quotient bit per ITER edge. LO = quotient, HI = remainder.
- Divide by zero (divisor == 0, DIV or DIVU):
  - FSM goes IDLE -> FIX directly; done asserts the cycle after E1.
  - HI/LO stay unchanged; dz=1.
- dz clears at the completion of any op with a nonzero divisor, and at reset.
- Signed overflow: INT_MIN / -1 gives LO=INT_MIN and HI=0, with no trap and dz=0.
- start while busy is ignored: no queueing, no error.
- hilo_wr while busy is ignored.
- start and hilo_wr together in IDLE: hilo_wr writes on E0, and the op is accepted on the same edge. The op's FIX result later overwrites HI/LO.
- start=1 on the cycle done is high is accepted normally, giving back-to-back ops.
- hi_out and lo_out change only on a FIX edge, a hilo_wr edge, or reset; never mid-iteration.

Decomposition:
- Shared package (int_dp_pkg) holds:
  - op encodings MULTU/MULT/DIVU/DIV;
  - FSM state enum IDLE/ITER/FIX;
  - hilo_wr bit positions.
- One sub-module: muldiv_iter_core. It is a parametrised WIDTH accumulator/shift step with no control or HI/LO state.
- The top holds the FSM, counter, sign capture, fix-up and HI/LO registers.

Test Plan:
1. MULT (WIDTH=32), s=0x00000007, t=0xFFFFFFFB -> done at cycle 33 after start; HI=0xFFFFFFFF, LO=0xFFFFFFDD, dz=0.
2. DIVU s=100, t=7 -> LO=0x0000000E, HI=0x00000002. Then DIV s=0xFFFFFFF9 (-7), t=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIV s=0x80000000, t=0xFFFFFFFF -> LO=0x80000000, HI=0, dz=0. Then DIV s=5, t=0 -> done 2 cycles after start, dz=1, HI/LO unchanged. Then MULTU 3*4 -> LO=0xC, dz=0.
4. hilo_wr=10 with s=0x1234 in IDLE -> HI=0x1234, LO unchanged. Start MULTU 2*2; at cycle 5 pulse start plus hilo_wr=11 -> both ignored; final LO=4, HI=0.
5. Start DIV 100/7; assert reset at cycle 10 -> busy=0, done=0, HI=LO=0 immediately. Release reset, restart DIVU 100/7 -> correct result, no residue.
6. Back-to-back: start asserted the cycle done is high -> second op accepted. Also WIDTH=8 instance: MULT 0x80*0x80 -> HI=0x40, LO=0x00, done 9 cycles after start.
